// File: rtl/vga_pkg.sv
// Shared VGA timing, framebuffer geometry and colour constants for the
// scan-out reader and the draw datapaths.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int unsigned FB_W       = 160;
  localparam int unsigned FB_H       = 120;
  localparam int unsigned FB_AW      = 15;
  localparam int unsigned SCALE_LOG2 = 2;
  localparam int unsigned CNT_W      = 10;

  typedef logic [23:0] rgb_t;

  localparam rgb_t BLACK     = 24'h000000;
  localparam rgb_t WHITE     = 24'hFFFFFF;
  localparam rgb_t CROSSHAIR = 24'hFF0000;
  localparam rgb_t BIRD      = 24'hFFD700;
  localparam rgb_t SKY       = 24'h87CEEB;

endpackage

// File: rtl/fb_scanout_if.sv
// Framebuffer read port plus VGA pin bundle; master is the scan-out side.
interface fb_scanout_if;
  import vga_pkg::*;

  logic [FB_AW-1:0] fb_addr;
  logic             fb_rd_en;
  rgb_t             fb_rdata;
  logic [7:0]       vga_r;
  logic [7:0]       vga_g;
  logic [7:0]       vga_b;
  logic             vga_hs;
  logic             vga_vs;
  logic             vga_blank_n;
  logic             vga_sync_n;
  logic             vga_clk;
  logic             frame_start;

  modport master (
    output fb_addr, fb_rd_en,
    output vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk,
    output frame_start,
    input  fb_rdata
  );

  modport slave (
    input  fb_addr, fb_rd_en,
    input  vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk,
    input  frame_start,
    output fb_rdata
  );

endinterface

// File: rtl/vga_timing_gen.sv
// Pixel-enable divider, h/v counters and the raw visible/sync/frame decode.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_pkg::V_BP
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      pix_en,
  output logic [vga_pkg::CNT_W-1:0] hcount,
  output logic [vga_pkg::CNT_W-1:0] vcount,
  output logic                      visible,
  output logic                      hs_raw,
  output logic                      vs_raw,
  output logic                      frame_start
);
  import vga_pkg::*;

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic             pix_en_q, pix_en_d;
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic             fs_q, fs_d;

  always_comb begin
    pix_en_d = ~pix_en_q;
    h_d      = h_q;
    v_d      = v_q;
    fs_d     = 1'b0;
    if (pix_en_q) begin
      if (h_q == CNT_W'(H_TOT - 1)) begin
        h_d = '0;
        if (v_q == CNT_W'(V_TOT - 1)) begin
          v_d  = '0;
          fs_d = 1'b1;
        end else begin
          v_d = v_q + 1'b1;
        end
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_en_q <= 1'b0;
      h_q      <= '0;
      v_q      <= '0;
      fs_q     <= 1'b0;
    end else begin
      pix_en_q <= pix_en_d;
      h_q      <= h_d;
      v_q      <= v_d;
      fs_q     <= fs_d;
    end
  end

  assign pix_en      = pix_en_q;
  assign hcount      = h_q;
  assign vcount      = v_q;
  assign frame_start = fs_q;
  assign visible     = (h_q < CNT_W'(H_ACTIVE)) && (v_q < CNT_W'(V_ACTIVE));
  assign hs_raw      = ~((h_q >= CNT_W'(H_ACTIVE + H_FP)) &&
                         (h_q <  CNT_W'(H_ACTIVE + H_FP + H_SYNC)));
  assign vs_raw      = ~((v_q >= CNT_W'(V_ACTIVE + V_FP)) &&
                         (v_q <  CNT_W'(V_ACTIVE + V_FP + V_SYNC)));

endmodule

// File: rtl/fb_scanout.sv
// 160x120 framebuffer scan-out: address generation and the two-stage
// RAM-read / pin-register pipeline, each screen pixel replicated 4x4.
module fb_scanout #(
  parameter int unsigned H_ACTIVE   = vga_pkg::H_ACTIVE,
  parameter int unsigned H_FP       = vga_pkg::H_FP,
  parameter int unsigned H_SYNC     = vga_pkg::H_SYNC,
  parameter int unsigned H_BP       = vga_pkg::H_BP,
  parameter int unsigned V_ACTIVE   = vga_pkg::V_ACTIVE,
  parameter int unsigned V_FP       = vga_pkg::V_FP,
  parameter int unsigned V_SYNC     = vga_pkg::V_SYNC,
  parameter int unsigned V_BP       = vga_pkg::V_BP,
  parameter int unsigned FB_W       = vga_pkg::FB_W,
  parameter int unsigned FB_H       = vga_pkg::FB_H,
  parameter int unsigned SCALE_LOG2 = vga_pkg::SCALE_LOG2
) (
  input  logic         clk,
  input  logic         reset,
  fb_scanout_if.master bus
);
  import vga_pkg::*;

  localparam logic [FB_AW-1:0] ADDR_MAX = FB_AW'(FB_W * FB_H - 1);

  logic             pix_en, visible, hs_raw, vs_raw, frame_start;
  logic [CNT_W-1:0] hcount, vcount;
  logic [FB_AW-1:0] row, col, idx;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .clk         (clk),
    .reset       (reset),
    .pix_en      (pix_en),
    .hcount      (hcount),
    .vcount      (vcount),
    .visible     (visible),
    .hs_raw      (hs_raw),
    .vs_raw      (vs_raw),
    .frame_start (frame_start)
  );

  // row*160 reduces to (row<<7)+(row<<5); the clamp only guards odd geometries
  assign row = FB_AW'(vcount >> SCALE_LOG2);
  assign col = FB_AW'(hcount >> SCALE_LOG2);
  assign idx = row * FB_AW'(FB_W) + col;

  logic [FB_AW-1:0] addr_q, addr_d;
  logic             rd_en_q, rd_en_d;
  logic             hs1_q, hs1_d, vs1_q, vs1_d, vis1_q, vis1_d;
  rgb_t             rgb_q, rgb_d;
  logic             hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;

  always_comb begin
    addr_d    = addr_q;
    rd_en_d   = rd_en_q;
    hs1_d     = hs1_q;
    vs1_d     = vs1_q;
    vis1_d    = vis1_q;
    rgb_d     = rgb_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    blank_n_d = blank_n_q;
    if (pix_en) begin
      if (visible) addr_d = (idx > ADDR_MAX) ? ADDR_MAX : idx;
      rd_en_d   = visible;
      hs1_d     = hs_raw;
      vs1_d     = vs_raw;
      vis1_d    = visible;
      rgb_d     = vis1_q ? bus.fb_rdata : BLACK;
      hs_d      = hs1_q;
      vs_d      = vs1_q;
      blank_n_d = vis1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= '0;
      rd_en_q   <= 1'b0;
      hs1_q     <= 1'b1;
      vs1_q     <= 1'b1;
      vis1_q    <= 1'b0;
      rgb_q     <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      rd_en_q   <= rd_en_d;
      hs1_q     <= hs1_d;
      vs1_q     <= vs1_d;
      vis1_q    <= vis1_d;
      rgb_q     <= rgb_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
    end
  end

  assign bus.fb_addr     = addr_q;
  assign bus.fb_rd_en    = rd_en_q;
  assign bus.vga_r       = rgb_q[23:16];
  assign bus.vga_g       = rgb_q[15:8];
  assign bus.vga_b       = rgb_q[7:0];
  assign bus.vga_hs      = hs_q;
  assign bus.vga_vs      = vs_q;
  assign bus.vga_blank_n = blank_n_q;
  assign bus.vga_sync_n  = 1'b0;
  assign bus.vga_clk     = pix_en;
  assign bus.frame_start = frame_start;

endmodule
